// File: rtl/soc_region_map.sv
// Runtime-programmable SoC address map with sticky per-region locks
// and a two-stage valid/ready address-to-target lookup pipeline.
module soc_region_map #(
  parameter int unsigned NrRegions = 10,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase = {
    64'h0000_0000, 64'h1000_4000, 64'h1000_3000,
    64'h1000_2000, 64'h1000_0000, 64'h0200_0000,
    64'h0C00_0000, 64'h3000_0000, 64'h0001_0000,
    64'h8000_0000},
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength = {
    64'h0000_1000, 64'h0000_1000, 64'h0000_1000,
    64'h0000_1000, 64'h0000_1000, 64'h0000_C000,
    64'h0400_0000, 64'h0000_1000, 64'h0001_0000,
    64'h4000_0000},
  parameter logic [NrRegions-1:0][2:0] RstCtrl =
    {NrRegions{3'b101}},
  parameter int unsigned IdxWidth =
    (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth+1:0]  cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_ack_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_exec_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_err_o
);

  logic [AddrWidth-1:0] r_base [NrRegions];
  logic [AddrWidth-1:0] r_len  [NrRegions];
  logic [2:0]           r_ctrl [NrRegions];

  logic                 r_cfg_ack;
  logic                 r_cfg_err;
  logic [AddrWidth-1:0] r_cfg_rdata;

  logic                 r_s1_valid;
  logic                 r_s1_exec;
  logic [NrRegions-1:0] r_s1_hit;
  logic [NrRegions-1:0] r_s1_xen;

  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic [IdxWidth-1:0]  r_rsp_idx;
  logic                 r_rsp_err;

  logic [IdxWidth-1:0]  w_idx;
  logic [1:0]           w_fld;
  logic                 w_idx_ok;
  logic                 w_lock;
  logic                 w_err;
  logic                 w_wr;
  logic [AddrWidth-1:0] w_rd;
  logic [NrRegions-1:0] w_hit;
  logic [NrRegions-1:0] w_xen;
  logic                 w_pe_hit;
  logic [IdxWidth-1:0]  w_pe_idx;
  logic                 w_pe_xen;
  logic                 w_pe_err;
  logic                 w_s2_free;
  logic                 w_take;

  assign w_idx    = cfg_addr_i[IdxWidth+1:2];
  assign w_fld    = cfg_addr_i[1:0];
  assign w_idx_ok = 32'(w_idx) < NrRegions;

  always_comb begin
    w_rd   = '0;
    w_lock = 1'b0;
    for (int i = 0; i < NrRegions; i++) begin
      if (w_idx == IdxWidth'(i)) begin
        w_lock = r_ctrl[i][1];
        unique case (w_fld)
          2'd0:    w_rd = r_base[i];
          2'd1:    w_rd = r_len[i];
          2'd2:    w_rd = AddrWidth'(r_ctrl[i]);
          default: w_rd = '0;
        endcase
      end
    end
  end

  assign w_err = !w_idx_ok || (w_fld == 2'd3) ||
                 (cfg_we_i && w_lock);
  assign w_wr  = cfg_req_i && cfg_we_i && !w_err;

  // Subtract-then-compare: an end address past 2^AddrWidth
  // simply covers the top of the space and never wraps.
  always_comb begin
    w_hit = '0;
    w_xen = '0;
    for (int i = 0; i < NrRegions; i++) begin
      w_hit[i] = r_ctrl[i][0] &&
                 (req_addr_i >= r_base[i]) &&
                 ((req_addr_i - r_base[i]) < r_len[i]);
      w_xen[i] = r_ctrl[i][2];
    end
  end

  always_comb begin
    w_pe_hit = 1'b0;
    w_pe_idx = '0;
    w_pe_xen = 1'b0;
    for (int i = NrRegions - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_pe_hit = 1'b1;
        w_pe_idx = IdxWidth'(i);
        w_pe_xen = r_s1_xen[i];
      end
    end
  end

  assign w_pe_err  = !w_pe_hit || (r_s1_exec && !w_pe_xen);
  assign w_s2_free = !r_rsp_valid || rsp_ready_i;
  assign w_take    = req_valid_i && req_ready_o;

  assign req_ready_o = !r_s1_valid || w_s2_free;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRegions; i++) begin
        r_base[i] <= RstBase[i];
        r_len[i]  <= RstLength[i];
        r_ctrl[i] <= RstCtrl[i];
      end
      r_cfg_ack   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_rdata <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_exec   <= 1'b0;
      r_s1_hit    <= '0;
      r_s1_xen    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cfg_ack   <= cfg_req_i;
      r_cfg_err   <= cfg_req_i && w_err;
      r_cfg_rdata <= (cfg_req_i && !cfg_we_i && !w_err)
                     ? w_rd : '0;
      for (int i = 0; i < NrRegions; i++) begin
        if (w_wr && w_idx == IdxWidth'(i)) begin
          unique case (w_fld)
            2'd0:    r_base[i] <= cfg_wdata_i;
            2'd1:    r_len[i]  <= cfg_wdata_i;
            2'd2:    r_ctrl[i] <= cfg_wdata_i[2:0];
            default: ;
          endcase
        end
      end
      if (w_take) begin
        r_s1_valid <= 1'b1;
        r_s1_exec  <= req_exec_i;
        r_s1_hit   <= w_hit;
        r_s1_xen   <= w_xen;
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_free) begin
        r_rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_hit <= w_pe_hit;
          r_rsp_idx <= w_pe_idx;
          r_rsp_err <= w_pe_err;
        end
      end
    end
  end

  assign cfg_ack_o   = r_cfg_ack;
  assign cfg_err_o   = r_cfg_err;
  assign cfg_rdata_o = r_cfg_rdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_soc_region_map.sv
// Scoreboard bench for soc_region_map: directed map scenarios
// followed by randomized config/lookup traffic.
module tb_soc_region_map;

  localparam int NR = 10;
  localparam int AW = 64;
  localparam int IW = 4;

  localparam logic [NR-1:0][AW-1:0] RB = {
    64'h0000_0000, 64'h1000_4000, 64'h1000_3000,
    64'h1000_2000, 64'h1000_0000, 64'h0200_0000,
    64'h0C00_0000, 64'h3000_0000, 64'h0001_0000,
    64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RL = {
    64'h0000_1000, 64'h0000_1000, 64'h0000_1000,
    64'h0000_1000, 64'h0000_1000, 64'h0000_C000,
    64'h0400_0000, 64'h0000_1000, 64'h0001_0000,
    64'h4000_0000};
  // UART (region 5) comes out of reset without execute permission
  localparam logic [NR-1:0][2:0] RC = {
    3'b101, 3'b101, 3'b101, 3'b101, 3'b001,
    3'b101, 3'b101, 3'b101, 3'b101, 3'b101};

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_req_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [IW+1:0] cfg_addr_i = '0;
  logic [AW-1:0] cfg_wdata_i = '0;
  logic          cfg_ack_o;
  logic [AW-1:0] cfg_rdata_o;
  logic          cfg_err_o;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_exec_i = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic          rsp_hit_o;
  logic [IW-1:0] rsp_idx_o;
  logic          rsp_err_o;

  soc_region_map #(
    .NrRegions(NR), .AddrWidth(AW),
    .RstBase(RB), .RstLength(RL), .RstCtrl(RC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_ack_o(cfg_ack_o), .cfg_rdata_o(cfg_rdata_o),
    .cfg_err_o(cfg_err_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_exec_i(req_exec_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_idx_o(rsp_idx_o),
    .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic          err;
    int            acc;
    bit            lat;
  } lk_t;

  typedef struct {
    logic [AW-1:0] rdata;
    logic          err;
    bit            rd;
    int            cyc;
  } cf_t;

  lk_t lk_q[$];
  cf_t cf_q[$];

  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [2:0]    m_ctrl [NR];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  g_rdy = 1'b1;
  bit  g_lat = 1'b1;

  bit            st_v = 1'b0;
  logic          st_hit;
  logic [IW-1:0] st_idx;
  logic          st_err;

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = RB[i];
      m_len[i]  = RL[i];
      m_ctrl[i] = RC[i];
    end
  endtask

  // Region i covers [base, base+len) in 65-bit arithmetic
  function automatic lk_t model_lookup(input logic [AW-1:0] a,
                                       input bit x);
    lk_t r;
    logic [AW:0] lo, hi, aa;
    r.hit = 1'b0; r.idx = '0; r.err = 1'b1;
    r.acc = 0;    r.lat = 1'b0;
    aa = {1'b0, a};
    for (int i = 0; i < NR; i++) begin
      lo = {1'b0, m_base[i]};
      hi = lo + {1'b0, m_len[i]};
      if (!r.hit && m_ctrl[i][0] && aa >= lo && aa < hi) begin
        r.hit = 1'b1;
        r.idx = IW'(i);
        r.err = x && !m_ctrl[i][2];
      end
    end
    return r;
  endfunction

  task automatic model_cfg(input bit we, input int idx,
                           input int fld,
                           input logic [AW-1:0] wd,
                           output cf_t r);
    r.rdata = '0; r.err = 1'b0; r.rd = !we; r.cyc = cyc;
    if (idx >= NR || fld == 3) begin
      r.err = 1'b1;
    end else if (!we) begin
      case (fld)
        0:       r.rdata = m_base[idx];
        1:       r.rdata = m_len[idx];
        default: r.rdata = {61'b0, m_ctrl[idx]};
      endcase
    end else if (m_ctrl[idx][1]) begin
      r.err = 1'b1;
    end else begin
      case (fld)
        0:       m_base[idx] = wd;
        1:       m_len[idx]  = wd;
        default: m_ctrl[idx] = wd[2:0];
      endcase
    end
  endtask

  // One clock of stimulus; lookup expectation uses pre-write map
  task automatic step(input bit creq, input bit cwe,
                      input int ci, input int cf,
                      input logic [AW-1:0] cwd, input bit rv,
                      input logic [AW-1:0] ra, input bit rx,
                      output bit acc);
    lk_t e;
    cf_t c;
    @(negedge clk_i);
    cfg_req_i   = creq;
    cfg_we_i    = cwe;
    cfg_addr_i  = {ci[IW-1:0], cf[1:0]};
    cfg_wdata_i = cwd;
    req_valid_i = rv;
    req_addr_i  = ra;
    req_exec_i  = rx;
    rsp_ready_i = g_rdy;
    #1;
    acc = rv && req_ready_o;
    if (acc) begin
      e = model_lookup(ra, rx);
      e.acc = cyc;
      e.lat = g_lat;
      lk_q.push_back(e);
    end
    if (creq) begin
      model_cfg(cwe, ci, cf, cwd, c);
      cf_q.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, 0, '0, 0, a);
  endtask

  task automatic cfg(input bit we, input int idx, input int fld,
                     input logic [AW-1:0] wd);
    bit a;
    step(1, we, idx, fld, wd, 0, '0, 0, a);
  endtask

  task automatic look(input logic [AW-1:0] ad, input bit x);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++)
      step(0, 0, 0, 0, '0, 1, ad, x, a);
    if (!a) chk("look_accept_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    cfg_req_i = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = g_rdy;
    lk_q.delete();
    cf_q.delete();
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
    chk("rst_rsp_hit", 64'(rsp_hit_o), 0);
    chk("rst_rsp_idx", 64'(rsp_idx_o), 0);
    chk("rst_rsp_err", 64'(rsp_err_o), 0);
    chk("rst_cfg_ack", 64'(cfg_ack_o), 0);
    chk("rst_cfg_rdata", cfg_rdata_o, 0);
    chk("rst_cfg_err", 64'(cfg_err_o), 0);
    chk("rst_req_ready", 64'(req_ready_o), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (lk_q.size() != 0 ||
         cf_q.size() != 0); k++)
      idle(1);
    idle(2);
    chk("drain_lookups", 64'(lk_q.size()), 0);
    chk("drain_cfg", 64'(cf_q.size()), 0);
  endtask

  task automatic monitor();
    lk_t e;
    cf_t c;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        st_v = 1'b0;
      end else begin
        if (cfg_ack_o) begin
          if (cf_q.size() == 0) begin
            chk("cfg_spurious_ack", 1, 0);
          end else begin
            c = cf_q.pop_front();
            chk("cfg_ack_time", 64'(cyc - c.cyc), 1);
            chk("cfg_err", 64'(cfg_err_o), 64'(c.err));
            if (c.rd) chk("cfg_rdata", cfg_rdata_o, c.rdata);
          end
        end
        if (st_v) begin
          chk("stall_valid", 64'(rsp_valid_o), 1);
          chk("stall_hit", 64'(rsp_hit_o), 64'(st_hit));
          chk("stall_idx", 64'(rsp_idx_o), 64'(st_idx));
          chk("stall_err", 64'(rsp_err_o), 64'(st_err));
        end
        st_v   = rsp_valid_o && !rsp_ready_i;
        st_hit = rsp_hit_o;
        st_idx = rsp_idx_o;
        st_err = rsp_err_o;
        if (rsp_valid_o && rsp_ready_i) begin
          if (lk_q.size() == 0) begin
            chk("rsp_spurious", 1, 0);
          end else begin
            e = lk_q.pop_front();
            chk("rsp_hit", 64'(rsp_hit_o), 64'(e.hit));
            chk("rsp_idx", 64'(rsp_idx_o), 64'(e.idx));
            chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
            if (e.lat) chk("rsp_latency", 64'(cyc - e.acc), 2);
          end
        end
      end
    end
  endtask

  function automatic logic [AW-1:0] gen_addr();
    int r;
    logic [AW-1:0] a;
    r = $urandom_range(0, NR - 1);
    case ($urandom_range(0, 4))
      0:       a = m_base[r];
      1:       a = m_base[r] - 1;
      2:       a = m_base[r] + m_len[r] - 1;
      3:       a = m_base[r] + m_len[r];
      default: a = {$urandom, $urandom};
    endcase
    return a;
  endfunction

  logic [AW-1:0] bp_addr [4];
  initial begin
    bit a, pv, px, cr, cw;
    int p, ci, cf;
    logic [AW-1:0] pa, wd;
    bp_addr[0] = 64'h1000_2000;
    bp_addr[1] = 64'h1000_3000;
    bp_addr[2] = 64'h1000_4000;
    bp_addr[3] = 64'h1000_1000;

    fork
      monitor();
    join_none

    do_reset();

    look(64'h8000_1000, 0);
    look(64'h1000_0FFF, 0);
    look(64'h1000_1000, 0);
    idle(4);
    look(64'h8000_0000, 1);
    look(64'h1000_0000, 1);
    idle(4);

    cfg(1, 2, 2, 64'h3);
    cfg(1, 2, 0, 64'h5000_0000);
    cfg(0, 2, 0, '0);
    cfg(0, 2, 2, '0);
    idle(3);
    do_reset();
    cfg(0, 2, 2, '0);
    cfg(0, 2, 0, '0);
    cfg(1, 2, 0, 64'h3000_0000);
    idle(2);

    step(1, 1, 0, 1, '0, 1, 64'h8000_0000, 0, a);
    chk("snap_accept", 64'(a), 1);
    look(64'h8000_0000, 0);
    cfg(1, 0, 1, 64'h4000_0000);
    idle(3);

    cfg(1, 3, 0, 64'h8000_0000);
    cfg(1, 3, 1, 64'h10);
    look(64'h8000_0008, 0);
    cfg(1, 9, 0, 64'hFFFF_FFFF_FFFF_FFF0);
    cfg(1, 9, 1, 64'h100);
    look(64'hFFFF_FFFF_FFFF_FFFF, 0);
    look(64'h0, 0);
    idle(3);

    cfg(0, 0, 3, '0);
    cfg(0, 12, 0, '0);
    cfg(1, 12, 1, 64'h55);
    cfg(1, 4, 3, 64'h55);
    idle(3);

    g_lat = 1'b0;
    p = 0;
    for (int t = 0; t < 20 && p < 4; t++) begin
      g_rdy = (t >= 3);
      step(0, 0, 0, 0, '0, 1, bp_addr[p], 0, a);
      if (t == 2) begin
        chk("bp_accepts", 64'(p), 2);
        chk("bp_ready_low", 64'(a), 0);
      end
      if (a) p++;
    end
    chk("bp_all_sent", 64'(p), 4);
    g_rdy = 1'b1;
    drain();
    g_lat = 1'b1;

    look(64'h8000_0000, 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(1);
      #3;
      chk("drop_no_rsp", 64'(rsp_valid_o), 0);
    end

    g_lat = 1'b0;
    pv = 1'b0;
    pa = '0;
    px = 1'b0;
    for (int it = 0; it < 800; it++) begin
      g_rdy = ($urandom_range(0, 3) != 0);
      if (!pv && $urandom_range(0, 1) == 1) begin
        pv = 1'b1;
        pa = gen_addr();
        px = $urandom_range(0, 1) == 1;
      end
      cr = $urandom_range(0, 2) == 0;
      cw = $urandom_range(0, 1) == 1;
      ci = $urandom_range(0, NR + 1);
      cf = $urandom_range(0, 3);
      case (cf)
        0: wd = gen_addr();
        1: wd = 64'($urandom_range(0, 32'h2000));
        default: begin
          wd = 64'($urandom_range(0, 7));
          if ($urandom_range(0, 15) != 0) wd[1] = 1'b0;
        end
      endcase
      step(cr, cw, ci, cf, wd, pv, pa, px, a);
      if (a) pv = 1'b0;
    end
    g_rdy = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
